enemy_collision_monitor: RTL
============================

Name: enemy_collision_monitor

Overview:
- Consumer of the enemy renderer's per-pixel outputs (enemy_region, enemy rgb) and the character renderer's per-pixel outputs during the VGA scan.
- Counts pixel-accurate, non-transparent character/enemy overlaps over each frame and judges a hit at frame end.
- Runs the damage FSM: lives counter, invulnerability window with blink, game-over flag.
- Feeds stage/scene control and the character renderer.

Parameters:
- LIVES_INIT, 3, lives loaded at reset and on entering stage 0
- INVULN_FRAMES, 120, frames of invulnerability after a hit (1..255)
- MIN_OVERLAP, 4, overlapping opaque pixels per frame required for a hit (1..4095)
- TRANSPARENT, 12'h0f0, colour-key value treated as empty
- H_LAST, 639, last visible pixel_x
- V_LAST, 479, last visible pixel_y

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- pixel_tick  in  1  qualifies a new pixel; all sampling gated by it
- stage  in  4  stage index; 0 = start screen, 1..9 = play, 10 = end
- pixel_x  in  10  current pixel x
- pixel_y  in  10  current pixel y
- enemy_region  in  3  per-enemy in-region flags, aligned with enemy_rgb
- enemy_rgb  in  12  composited enemy colour for this pixel
- chara_region  in  1  character in-region flag
- chara_rgb  in  12  character colour for this pixel
- hit_pulse  out  1  one-clk pulse on a judged hit
- hit_mask  out  3  enemies contributing to the last judged hit
- lives  out  3  remaining lives
- invuln  out  1  high while invulnerable
- blink  out  1  character-hide strobe during invulnerability
- game_over  out  1  sticky until stage 0

Behaviour:
- Reset (reset_n=0 at posedge clk): hit_pulse=0, hit_mask=0, lives=LIVES_INIT, invuln=0, blink=0, game_over=0, FSM=ALIVE, accumulators=0, inv_cnt=0, prev_stage=stage.
- Detection is active only when stage is in 1..9.
- An overlap pixel requires: pixel_tick, active, chara_region, chara_rgb!=TRANSPARENT, |enemy_region, enemy_rgb!=TRANSPARENT. Input pipeline alignment is the top level's responsibility.
- On each overlap pixel: ov_cnt (12-bit) increments, saturating at 4095; ov_mask |= enemy_region.
- Frame end = pixel_tick && pixel_x==H_LAST && pixel_y==V_LAST.
  - The frame-end pixel's own overlap is included in that frame's evaluation.
  - Accumulators clear on the same edge.
- FSM states: ALIVE, INVULN, DEAD. All transitions happen only at frame end, except the stage rules below.
  - ALIVE, count>=MIN_OVERLAP, lives>1: hit_pulse=1 for the following cycle, hit_mask=ov_mask, lives-1, inv_cnt=INVULN_FRAMES, go to INVULN.
  - ALIVE, count>=MIN_OVERLAP, lives==1: hit_pulse=1, hit_mask=ov_mask, lives=0, game_over=1, go to DEAD.
  - ALIVE, count<MIN_OVERLAP: no change.
  - INVULN: inv_cnt decrements each frame end. When it reaches 0, go to ALIVE. Overlaps in that frame are ignored; no hit is judged on the frame end that exits INVULN.
  - DEAD: ignores overlaps. Leaves only when stage==0.
- Output timing:
  - hit_pulse, lives, hit_mask, invuln and game_over all update on the clock edge that samples frame end (registered; visible next cycle).
  - hit_pulse deasserts the cycle after.
- invuln = (FSM==INVULN).
- blink = inv_cnt[3] while INVULN, else 0.
- Stage handling (prev_stage registered every clk; change = prev_stage!=stage):
  - On change: clear accumulators.
  - Entering stage 0 also forces ALIVE, lives=LIVES_INIT, game_over=0, inv_cnt=0.
  - A change between play stages keeps lives and FSM state. INVULN continues.
  - Stage change has priority over a frame end in the same cycle.
- While stage is 0 or 10, accumulators hold 0 and no hit is judged.
- Reset mid-INVULN or mid-frame: full reset values apply immediately; no pulse is emitted.
- lives never underflows below 0.

Test Plan:
- Reset with stage=1 -> lives=3, invuln=0, game_over=0, hit_pulse=0.
- Stage 1, 4 opaque overlap pixels with enemy_region=3'b010 in one frame -> hit_pulse for 1 clk after frame end, hit_mask=3'b010, lives=2, invuln=1. Repeat with 3 pixels -> no hit.
- Overlap pixels where enemy_rgb=12'h0f0 or chara_rgb=12'h0f0 (100 of them) -> no hit, lives unchanged.
- After a hit, 200 overlap pixels per frame for 120 frames -> no further hits. blink toggles every 8 frames. invuln drops at the 120th frame end. The next overlapping frame -> hit, lives=1.
- Three hits separated by invulnerability windows -> lives=0, game_over=1. Further overlaps ignored. Set stage=0 -> lives=3, game_over=0, FSM=ALIVE.
- Assert reset_n=0 during INVULN, and separately change stage 2->3 coinciding with frame end after 10 overlaps -> reset values restored; the stage change clears the count and no hit_pulse is emitted.

Source files
------------

// File: rtl/enemy_collision_monitor.sv
// enemy_collision_monitor: per-frame character/enemy overlap counting and damage FSM (lives, invulnerability, game over)
module enemy_collision_monitor #(
  parameter int          LIVES_INIT    = 3,
  parameter int          INVULN_FRAMES = 120,
  parameter int          MIN_OVERLAP   = 4,
  parameter logic [11:0] TRANSPARENT   = 12'h0f0,
  parameter int          H_LAST        = 639,
  parameter int          V_LAST        = 479
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_tick,
  input  logic [3:0]  stage,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [2:0]  enemy_region,
  input  logic [11:0] enemy_rgb,
  input  logic        chara_region,
  input  logic [11:0] chara_rgb,
  output logic        hit_pulse,
  output logic [2:0]  hit_mask,
  output logic [2:0]  lives,
  output logic        invuln,
  output logic        blink,
  output logic        game_over
);
  localparam logic [2:0]  LIVES0 = 3'(LIVES_INIT);
  localparam logic [7:0]  INV0   = 8'(INVULN_FRAMES);
  localparam logic [11:0] MIN_OV = 12'(MIN_OVERLAP);
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;
  state_t      state;
  logic [3:0]  prev_stage;
  logic [11:0] ov_cnt;
  logic [2:0]  ov_mask;
  logic [7:0]  inv_cnt;
  logic        active;
  logic        overlap;
  logic        frame_end;
  logic        change;
  logic [11:0] cnt_eval;
  logic [2:0]  mask_eval;
  logic [7:0]  inv_dec;
  logic        hit;
  // Pixel qualification and the frame's totals including the current pixel, so the frame-end pixel is judged too
  always_comb begin
    active    = stage >= 4'd1 && stage <= 4'd9;
    overlap   = pixel_tick && active && chara_region && chara_rgb != TRANSPARENT &&
                (|enemy_region) && enemy_rgb != TRANSPARENT;
    frame_end = pixel_tick && pixel_x == 10'(H_LAST) && pixel_y == 10'(V_LAST);
    change    = prev_stage != stage;
    cnt_eval  = (overlap && ov_cnt != 12'hfff) ? ov_cnt + 12'd1 : ov_cnt;
    mask_eval = overlap ? ov_mask | enemy_region : ov_mask;
    inv_dec   = inv_cnt - 8'd1;
    hit       = state == ALIVE && active && cnt_eval >= MIN_OV;
  end
  // Previous stage is tracked every cycle (reset included) so a change is seen exactly once
  always_ff @(posedge clk) prev_stage <= stage;
  // Overlap accumulators: cleared on reset, stage change, frame end and outside play stages
  always_ff @(posedge clk) begin
    if (!reset_n || change || frame_end || !active) begin
      ov_cnt  <= '0;
      ov_mask <= '0;
    end else begin
      ov_cnt  <= cnt_eval;
      ov_mask <= mask_eval;
    end
  end
  // Damage FSM with registered outputs; a stage change takes priority over a frame end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ALIVE;
      hit_pulse <= 1'b0;
      hit_mask  <= '0;
      lives     <= LIVES0;
      inv_cnt   <= '0;
      invuln    <= 1'b0;
      blink     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (change) begin
        if (stage == 4'd0) begin
          state     <= ALIVE;
          lives     <= LIVES0;
          game_over <= 1'b0;
          inv_cnt   <= '0;
          invuln    <= 1'b0;
          blink     <= 1'b0;
        end
      end else if (frame_end) begin
        case (state)
          ALIVE: begin
            if (hit) begin
              hit_pulse <= 1'b1;
              hit_mask  <= mask_eval;
              if (lives > 3'd1) begin
                lives   <= lives - 3'd1;
                inv_cnt <= INV0;
                state   <= INVULN;
                invuln  <= 1'b1;
                blink   <= INV0[3];
              end else begin
                lives     <= 3'd0;
                game_over <= 1'b1;
                state     <= DEAD;
              end
            end
          end
          INVULN: begin
            inv_cnt <= inv_dec;
            state   <= inv_dec == 8'd0 ? ALIVE : INVULN;
            invuln  <= inv_dec != 8'd0;
            blink   <= inv_dec != 8'd0 && inv_dec[3];
          end
          default: ;
        endcase
      end
    end
  end
endmodule
